// File: rtl/imem_load_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
// Pulled in by imem_word_assembler and imem_load_arbiter.
package imem_load_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_COLLECT,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam int          BYTES_PER_WORD   = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Byte-serial to 32-bit word assembler, MSB-first, with an optional running byte sum.
// Optional checksum accumulator enabled by IMEM_LOAD_CHECKSUM_EN.
module imem_word_assembler
    import imem_load_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [7:0]  o_sum
`endif
);

    logic [31:0] r_word;
    logic [1:0]  r_count;

    // The 2-bit counter wraps to 0 on the 4th byte, so the next word starts clean
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_word  <= {r_word[23:0], i_byte};
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_shift && (r_count == 2'(BYTES_PER_WORD - 1));

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sum <= '0;
        end else if (i_shift) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_sum = r_sum;
`endif

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the instruction memory port between CPU fetch and a byte-serial program loader.
// Optional trailer-byte checksum enabled by IMEM_LOAD_CHECKSUM_EN.
module imem_load_arbiter
    import imem_load_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_fetch_addr,
    output logic [31:0]       o_fetch_instr,
    output logic              o_fetch_fault,
    output logic              o_cpu_hold,
    output logic              o_cpu_restart,
    input  logic              i_load_start,
    input  logic [ADDR_W:0]   i_load_words,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_byte,
    output logic              o_load_ready,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_nextPtr;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     w_nextLen;
    logic                r_loadErr;
    logic                w_nextErr;
    logic [ADDR_W:0]     w_satLen;
    logic                w_upperNonzero;
    logic                w_loadReady;
    logic                w_accept;
    logic                w_shift;
    logic                w_clear;
    logic                w_wordReady;
    logic                w_lastWord;
    logic [31:0]         w_word;
    logic [1:0]          w_unusedLowBits;

    assign w_unusedLowBits = i_fetch_addr[1:0];

    assign w_satLen       = (i_load_words > DEPTH_L) ? DEPTH_L : i_load_words;
    assign w_upperNonzero = (i_fetch_addr[31:ADDR_W+2] != '0);
    assign w_lastWord     = ({1'b0, r_ptr} == (r_len - 1'b1));

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] w_sum;
    logic [7:0] w_sumWithTrailer;

    assign w_loadReady      = (r_state == ST_COLLECT) || (r_state == ST_CHECK);
    assign w_sumWithTrailer = w_sum + i_load_byte;
`else
    assign w_loadReady = (r_state == ST_COLLECT);
`endif

    assign w_accept = i_load_valid && w_loadReady;
    assign w_shift  = w_accept && (r_state == ST_COLLECT);
    assign w_clear  = (r_state == ST_RUN) && i_load_start;

    imem_word_assembler u_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_byte       (i_load_byte),
        .o_word       (w_word),
        .o_word_ready (w_wordReady)
`ifdef IMEM_LOAD_CHECKSUM_EN
        ,
        .o_sum        (w_sum)
`endif
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_RUN;
            r_ptr     <= '0;
            r_len     <= '0;
            r_loadErr <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ptr     <= w_nextPtr;
            r_len     <= w_nextLen;
            r_loadErr <= w_nextErr;
        end
    end

    // Fetch sees memory directly in RUN; every other state owns the port for the loader
    always_comb begin
        w_nextState   = r_state;
        w_nextPtr     = r_ptr;
        w_nextLen     = r_len;
        w_nextErr     = r_loadErr;
        o_fetch_instr = NOP_WORD;
        o_fetch_fault = 1'b0;
        o_cpu_hold    = 1'b1;
        o_cpu_restart = 1'b0;
        o_load_done   = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = r_ptr;

        case (r_state)
            ST_RUN: begin
                o_cpu_hold    = 1'b0;
                o_mem_addr    = i_fetch_addr[ADDR_W+1:2];
                o_fetch_fault = w_upperNonzero;
                o_fetch_instr = w_upperNonzero ? NOP_WORD : i_mem_rdata;
                if (i_load_start) begin
                    w_nextLen   = w_satLen;
                    w_nextPtr   = '0;
                    w_nextErr   = 1'b0;
                    w_nextState = (w_satLen == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_wordReady) begin
                    w_nextState = ST_WRITE;
                end
            end
            ST_WRITE: begin
                o_mem_we = 1'b1;
                if (w_lastWord) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    w_nextState = ST_CHECK;
`else
                    w_nextState = ST_DONE;
`endif
                end else begin
                    w_nextPtr   = r_ptr + 1'b1;
                    w_nextState = ST_COLLECT;
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    w_nextErr   = (w_sumWithTrailer != 8'h00);
                    w_nextState = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                o_load_done   = 1'b1;
                o_cpu_restart = 1'b1;
                w_nextPtr     = '0;
                w_nextState   = ST_RUN;
            end
            default: begin
                w_nextPtr   = '0;
                w_nextState = ST_RUN;
            end
        endcase
    end

    assign o_load_ready = w_loadReady;
    assign o_mem_wdata  = w_word;

`ifdef IMEM_LOAD_CHECKSUM_EN
    assign o_load_err = r_loadErr;
`else
    assign o_load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter: expected memory writes go into a
// scoreboard queue and are popped by a write monitor. Define IMEM_LOAD_CHECKSUM_EN for checksum tests.
module tb_imem_load_arbiter;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       fetchAddr = '0;
    logic [31:0]       fetchInstr;
    logic              fetchFault;
    logic              cpuHold;
    logic              cpuRestart;
    logic              loadStart = 1'b0;
    logic [ADDR_W:0]   loadWords = '0;
    logic              loadValid = 1'b0;
    logic [7:0]        loadByte = '0;
    logic              loadReady;
    logic              loadDone;
    logic              loadErr;
    logic [ADDR_W-1:0] memAddr;
    logic              memWe;
    logic [31:0]       memWdata;
    logic [31:0]       memRdata = '0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  failures = 0;
    int  writeCount = 0;
    int  restartCount = 0;
    logic [7:0] runSum;

    imem_load_arbiter #(.ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_fetch_addr(fetchAddr), .o_fetch_instr(fetchInstr), .o_fetch_fault(fetchFault),
        .o_cpu_hold(cpuHold), .o_cpu_restart(cpuRestart),
        .i_load_start(loadStart), .i_load_words(loadWords),
        .i_load_valid(loadValid), .i_load_byte(loadByte),
        .o_load_ready(loadReady), .o_load_done(loadDone), .o_load_err(loadErr),
        .o_mem_addr(memAddr), .o_mem_we(memWe), .o_mem_wdata(memWdata),
        .i_mem_rdata(memRdata)
    );

    always #5 clk = ~clk;

    // Write monitor: every memory write must match the head of the scoreboard
    always @(negedge clk) begin
        if (cpuRestart) restartCount++;
        if (memWe) begin
            wr_t e;
            writeCount++;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write addr=%0d data=%h required=none", memAddr, memWdata);
            end else begin
                e = expQ.pop_front();
                if (memAddr !== e.addr || memWdata !== e.data) begin
                    failures++;
                    $display("[TB] FAIL write addr=%0d data=%h required addr=%0d data=%h",
                             memAddr, memWdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic pulseStart(input int words);
        loadWords = (ADDR_W+1)'(words);
        loadStart = 1'b1;
        @(posedge clk); #1;
        loadStart = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit got = 0;
        loadValid = 1'b1;
        loadByte  = b;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (loadReady) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL byte_accept ready=0 required=1 byte=%h", b);
        end
        @(posedge clk); #1;
        loadValid = 1'b0;
        runSum = runSum + b;
    endtask

    task automatic sendWord(input int addr, input logic [31:0] w);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = w;
        expQ.push_back(e);
        sendByte(w[31:24]);
        sendByte(w[23:16]);
        sendByte(w[15:8]);
        sendByte(w[7:0]);
    endtask

    // Waits for the done cycle, checks its outputs, then the cycle after it
    task automatic waitDone(input logic expErr);
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (loadDone) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL load_done_timeout done=0 required=1");
        end
        checks++;
        if (cpuRestart !== 1'b1 || cpuHold !== 1'b1 || loadErr !== expErr) begin
            failures++;
            $display("[TB] FAIL done_cycle restart=%b hold=%b err=%b required 1 1 %b",
                     cpuRestart, cpuHold, loadErr, expErr);
        end
        @(negedge clk);
        checks++;
        if (loadDone !== 1'b0 || cpuRestart !== 1'b0 || cpuHold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_done done=%b restart=%b hold=%b required 0 0 0",
                     loadDone, cpuRestart, cpuHold);
        end
    endtask

    task automatic checkDrained(input string name, input int expWrites);
        checks++;
        if (writeCount !== expWrites || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s writes=%0d pending=%0d required writes=%0d pending=0",
                     name, writeCount, expQ.size(), expWrites);
        end
    endtask

    task automatic sendTrailer(input logic [7:0] delta);
`ifdef IMEM_LOAD_CHECKSUM_EN
        logic [7:0] t;
        t = 8'(-runSum) + delta;
        sendByte(t);
`else
        if (delta != 0) $display("[TB] trailer ignored without checksum build");
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cpuHold !== 0 || cpuRestart !== 0 || loadReady !== 0 || loadDone !== 0 ||
            loadErr !== 0 || memWe !== 0 || memWdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state hold=%b rst=%b rdy=%b done=%b err=%b we=%b wdata=%h required all 0",
                     cpuHold, cpuRestart, loadReady, loadDone, loadErr, memWe, memWdata);
        end
    endtask

    task automatic test_fetch();
        fetchAddr = 32'h0000_0008;
        memRdata  = 32'h308b_f000;
        @(negedge clk);
        checks++;
        if (fetchInstr !== 32'h308b_f000 || cpuHold !== 0 || fetchFault !== 0 || memWe !== 0 || memAddr !== 8'd2) begin
            failures++;
            $display("[TB] FAIL fetch_pass instr=%h hold=%b fault=%b we=%b addr=%0d required 308bf000 0 0 0 2",
                     fetchInstr, cpuHold, fetchFault, memWe, memAddr);
        end
        fetchAddr = 32'h0000_0400;
        @(negedge clk);
        checks++;
        if (fetchInstr !== 32'h0 || fetchFault !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fetch_fault instr=%h fault=%b required 00000000 1", fetchInstr, fetchFault);
        end
        fetchAddr = 32'h0000_0004;
        @(posedge clk); #1;
    endtask

    task automatic test_load_two_words();
        int base = writeCount;
        runSum = 8'h00;
        pulseStart(2);
        sendWord(0, 32'h2004_004e);
        sendWord(1, 32'h3c10_4000);
        sendTrailer(8'h00);
        waitDone(1'b0);
        checkDrained("two_words", base + 2);
    endtask

    task automatic test_zero_len();
        int base = writeCount;
        pulseStart(0);
        @(negedge clk);
        checks++;
        if (loadDone !== 1'b1 || cpuRestart !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_len done=%b restart=%b required 1 1", loadDone, cpuRestart);
        end
        @(negedge clk);
        checks++;
        if (loadDone !== 1'b0 || cpuHold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_len_after done=%b hold=%b required 0 0", loadDone, cpuHold);
        end
        checkDrained("zero_len", base);
    endtask

    task automatic test_saturate();
        int base = writeCount;
        runSum = 8'h00;
        pulseStart(300);
        for (int i = 0; i < 256; i++) begin
            sendWord(i, {8'(i), 8'(i * 3 + 1), 8'hA5 ^ 8'(i), 8'h3C});
        end
        sendTrailer(8'h00);
        waitDone(1'b0);
        checkDrained("saturate", base + 256);
    endtask

    task automatic test_reset_midload();
        int baseW = writeCount;
        int baseR = restartCount;
        runSum = 8'h00;
        pulseStart(1);
        sendByte(8'h11);
        sendByte(8'h22);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cpuHold !== 0 || loadReady !== 0 || cpuRestart !== 0) begin
            failures++;
            $display("[TB] FAIL reset_midload hold=%b ready=%b restart=%b required 0 0 0",
                     cpuHold, loadReady, cpuRestart);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (restartCount !== baseR || writeCount !== baseW) begin
            failures++;
            $display("[TB] FAIL reset_midload_quiet restarts=%0d writes=%0d required %0d %0d",
                     restartCount, writeCount, baseR, baseW);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int base = writeCount;
        runSum = 8'h00;
        pulseStart(1);
        sendWord(0, 32'hdead_beef);
        sendTrailer(8'h00);
        waitDone(1'b0);
        checkDrained("after_reset_load", base + 1);
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        runSum = 8'h00;
        pulseStart(1);
        sendWord(0, 32'h0102_0304);
        sendByte(8'hF6);
        waitDone(1'b0);
        runSum = 8'h00;
        pulseStart(1);
        sendWord(0, 32'h0102_0304);
        sendByte(8'hF5);
        waitDone(1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (loadErr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_sticky err=%b required 1", loadErr);
        end
        @(posedge clk); #1;
        pulseStart(0);
        @(negedge clk);
        checks++;
        if (loadErr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_cleared err=%b required 0", loadErr);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_load_two_words();
        test_zero_len();
        test_saturate();
        test_reset_midload();
        test_back_to_back();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout reached required finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Sits between the CPU fetch port and the writable instruction memory.
- Shares the memory's single port between instruction fetch and a byte-serial program loader (UART receive path).
- A load stalls the CPU, assembles bytes into words MSB-first, and writes them from word 0.
- When the load completes, it pulses a CPU restart so the new program runs from PC 0.

Parameters:
- ADDR_W, 8, word-address width of instruction memory (DEPTH = 2**ADDR_W words, PC bits [ADDR_W+1:2]).
- NOP_WORD, 32'h00000000, instruction returned to fetch while stalled or out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- fetch_addr  in  32  CPU PC (byte address)
- fetch_instr  out  32  instruction to CPU
- fetch_fault  out  1  fetch_addr[31:ADDR_W+2] nonzero in RUN
- cpu_hold  out  1  CPU must not advance PC
- cpu_restart  out  1  one-cycle pulse: CPU resets PC to 0
- load_start  in  1  begin load (pulse)
- load_words  in  ADDR_W+1  number of words to load, sampled on load_start
- load_valid  in  1  load_byte valid
- load_byte  in  8  loader data byte
- load_ready  out  1  byte accepted when load_valid && load_ready
- load_done  out  1  one-cycle pulse at load end
- load_err  out  1  checksum error, sticky until next load_start (feature only)
- mem_addr  out  ADDR_W  memory word address
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data

Behaviour:
- Reset values:
  - State RUN, word pointer 0, byte count 0.
  - cpu_hold 0, cpu_restart 0, load_ready 0, load_done 0, load_err 0, mem_we 0, mem_wdata 0.
- States: RUN, COLLECT, WRITE, (CHECK), DONE.
- RUN:
  - mem_addr = fetch_addr[ADDR_W+1:2].
  - fetch_instr = mem_rdata, or NOP_WORD with fetch_fault=1 when upper address bits are nonzero.
  - Zero added latency (combinational path).
  - load_start → COLLECT. len = min(load_words, DEPTH); if len==0 → DONE directly.
- COLLECT:
  - cpu_hold=1, fetch_instr=NOP_WORD, fetch_fault=0, load_ready=1.
  - Each accepted byte shifts into the word register: first byte → bits [31:24].
  - On the 4th accepted byte → WRITE.
- WRITE (one cycle):
  - load_ready=0, mem_we=1, mem_addr=ptr, mem_wdata=assembled word.
  - If ptr==len-1 → DONE (or CHECK when feature on). Otherwise ptr++, byte count 0, → COLLECT.
- DONE (one cycle): cpu_hold=1, load_done=1, cpu_restart=1; next state RUN with ptr=0.
- mem_we is never high outside WRITE; at most one write per word.
- load_start outside RUN is ignored.
- load_valid outside COLLECT/CHECK is ignored (load_ready=0).
- Reset mid-load:
  - Immediate return to RUN next edge, no restart pulse.
  - Partially written memory contents are left as-is.
- Pointer never wraps: len is saturated to DEPTH, so a DEPTH-word load ends at ptr=DEPTH-1.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- With the macro:
  - An 8-bit running sum of all data bytes (mod 256) is kept.
  - After the last WRITE the block enters CHECK with load_ready=1 and accepts one trailing byte.
  - load_err = (sum + trailer) != 8'h00, set in the DONE cycle.
  - The restart pulse is still issued.
- Without the macro: no CHECK state, no trailer byte, load_err tied 0.

Decomposition:
- Package imem_load_pkg holds:
  - The state enum (RUN, COLLECT, WRITE, CHECK, DONE).
  - NOP_WORD default.
  - Byte-per-word constant 4.
- One sub-module: imem_word_assembler (byte shift register, 2-bit byte counter, word_ready flag, optional checksum accumulator).
- The FSM and port mux stay in the top module.

Test Plan:
- Reset then fetch_addr=32'h0000_0008, mem_rdata=32'h308bf000 → fetch_instr=32'h308bf000, cpu_hold=0, fetch_fault=0, mem_we=0.
- fetch_addr=32'h0000_0400 (ADDR_W=8) → fetch_instr=0, fetch_fault=1.
- load_start with load_words=2, bytes 20 04 00 4e 3c 10 40 00 sent back-to-back →
  - mem_we pulses twice: addr 0 data 32'h2004004e, addr 1 data 32'h3c104000.
  - Then load_done and cpu_restart are high for exactly one cycle; cpu_hold drops on the following cycle.
- load_words=0 → DONE on the next cycle, no mem_we. load_words=300 → len saturates to 256, last write at addr 255.
- Reset asserted after 2 of 4 bytes of word 0 → RUN next cycle, no mem_we, no cpu_restart. A later load_start loads cleanly.
- With IMEM_LOAD_CHECKSUM_EN, one-word load 01 02 03 04:
  - Trailer 8'hF6 → load_err=0.
  - Trailer 8'hF5 → load_err=1 and stays 1 until the next load_start.
